// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interface logic.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        GAP  = 3'd2,
        P2   = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam int PULSE_W_DEF = 2;
    localparam int GAP_W_DEF   = 2;

    // The 8259 answers an unclaimed acknowledge with its IR7 vector.
    localparam logic [2:0] SPURIOUS_IR = 3'b111;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; resets asynchronously to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode two-pulse INTA sequencer: captures the PIC vector and offers it to the CPU.
// Optional INTA_SPURIOUS_DETECT_EN adds vec_spurious for IR7 vectors returned after INT was withdrawn.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int GAP_W   = GAP_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_in,
    input  logic       cpu_ien,
    input  logic [7:0] d_in,
    output logic       inta_n,
    output logic [7:0] vec,
    output logic       vec_valid,
    input  logic       vec_ack,
    output logic       busy
`ifdef INTA_SPURIOUS_DETECT_EN
    ,
    output logic       vec_spurious
`endif
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

    logic             int_sync;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             inta_n_q;
    logic [7:0]       vec_q;
    logic             vec_valid_q;
`ifdef INTA_SPURIOUS_DETECT_EN
    logic             int_at_p1_end_q;
    logic             vec_spurious_q;
`endif

    sync_2ff u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (int_in),
        .q_o   (int_sync)
    );

    // Once P1 is entered the sequence always runs to HOLD; inputs only gate the start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            inta_n_q    <= 1'b1;
            vec_q       <= 8'h00;
            vec_valid_q <= 1'b0;
`ifdef INTA_SPURIOUS_DETECT_EN
            int_at_p1_end_q <= 1'b0;
            vec_spurious_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (int_sync && cpu_ien) begin
                        state_q  <= P1;
                        cnt_q    <= '0;
                        inta_n_q <= 1'b0;
                    end
                end
                P1: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q  <= GAP;
                        cnt_q    <= '0;
                        inta_n_q <= 1'b1;
`ifdef INTA_SPURIOUS_DETECT_EN
                        int_at_p1_end_q <= int_sync;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q  <= P2;
                        cnt_q    <= '0;
                        inta_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                P2: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        inta_n_q    <= 1'b1;
                        vec_q       <= d_in;
                        vec_valid_q <= 1'b1;
`ifdef INTA_SPURIOUS_DETECT_EN
                        vec_spurious_q <= !int_at_p1_end_q && (d_in[2:0] == SPURIOUS_IR);
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (vec_ack) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        vec_valid_q <= 1'b0;
`ifdef INTA_SPURIOUS_DETECT_EN
                        vec_spurious_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    inta_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign inta_n    = inta_n_q;
    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign busy      = (state_q != IDLE);
`ifdef INTA_SPURIOUS_DETECT_EN
    assign vec_spurious = vec_spurious_q;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: default (2/2) and swept (1/3) instances against a timeline model.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       int_in = 1'b0;
    logic       cpu_ien = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       vec_ack = 1'b0;

    logic [1:0] o_inta;
    logic [1:0] o_valid;
    logic [1:0] o_busy;
    logic [7:0] o_vec [2];
`ifdef INTA_SPURIOUS_DETECT_EN
    logic [1:0] o_spur;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    inta_sequencer #(.PULSE_W(2), .GAP_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .int_in(int_in), .cpu_ien(cpu_ien), .d_in(d_in),
        .inta_n(o_inta[0]), .vec(o_vec[0]), .vec_valid(o_valid[0]), .vec_ack(vec_ack),
        .busy(o_busy[0])
`ifdef INTA_SPURIOUS_DETECT_EN
        , .vec_spurious(o_spur[0])
`endif
    );

    inta_sequencer #(.PULSE_W(1), .GAP_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .int_in(int_in), .cpu_ien(cpu_ien), .d_in(d_in),
        .inta_n(o_inta[1]), .vec(o_vec[1]), .vec_valid(o_valid[1]), .vec_ack(vec_ack),
        .busy(o_busy[1])
`ifdef INTA_SPURIOUS_DETECT_EN
        , .vec_spurious(o_spur[1])
`endif
    );

    function automatic int pw(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int gw(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is a timeline of edges counted from its start edge.
    int         m_edge;
    int         m_start [2];
    bit         m_busy  [2];
    bit         m_valid [2];
    bit         m_inta  [2];
    bit         m_samp  [2];
    bit         m_spur  [2];
    logic [7:0] m_vec   [2];
    bit         hist [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge = 0;
            hist.delete();
            for (int i = 0; i < 2; i++) begin
                m_start[i] = 0; m_busy[i] = 0; m_valid[i] = 0; m_inta[i] = 1;
                m_samp[i] = 0; m_spur[i] = 0; m_vec[i] = 8'h00;
            end
        end else begin
            bit sync_seen;
            m_edge++;
            sync_seen = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
            for (int i = 0; i < 2; i++) begin
                int ph;
                ph = m_edge - m_start[i];
                if (m_valid[i]) begin
                    if (vec_ack) begin
                        m_valid[i] = 0; m_busy[i] = 0; m_spur[i] = 0;
                    end
                end else if (m_busy[i]) begin
                    if (ph == pw(i)) m_samp[i] = sync_seen;
                    if (ph == 2*pw(i) + gw(i)) begin
                        m_valid[i] = 1;
                        m_vec[i]   = d_in;
                        m_spur[i]  = !m_samp[i] && (d_in[2:0] == 3'b111);
                    end
                end else if (sync_seen && cpu_ien) begin
                    m_busy[i]  = 1;
                    m_start[i] = m_edge;
                end
                ph = m_edge - m_start[i];
                m_inta[i] = !(m_busy[i] && !m_valid[i] &&
                              (ph < pw(i) || (ph >= pw(i) + gw(i) && ph < 2*pw(i) + gw(i))));
            end
            hist.push_back(int_in);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("inta_n[%0d]", i), {31'b0, o_inta[i]}, {31'b0, m_inta[i]});
                chk($sformatf("busy[%0d]", i), {31'b0, o_busy[i]}, {31'b0, m_busy[i]});
                chk($sformatf("vec_valid[%0d]", i), {31'b0, o_valid[i]}, {31'b0, m_valid[i]});
                chk($sformatf("vec[%0d]", i), {24'b0, o_vec[i]}, {24'b0, m_vec[i]});
`ifdef INTA_SPURIOUS_DETECT_EN
                chk($sformatf("vec_spurious[%0d]", i), {31'b0, o_spur[i]}, {31'b0, m_spur[i]});
`endif
            end
        end
    end

    task automatic after_edge(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int_in  = 1'b0;
        cpu_ien = 1'b1;
        after_edge(20);
        vec_ack = 1'b1;
        after_edge(2);
        vec_ack = 1'b0;
        after_edge(4);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        after_edge(3);
        chk("reset_inta_n", {31'b0, o_inta[0]}, 32'd1);
        chk("reset_vec", {24'b0, o_vec[0]}, 32'h00);
        rst_n = 1'b1;
        cpu_ien = 1'b1;
        d_in = 8'h4B;
        after_edge(2);

        // Basic: int_in first sampled high on edge 0
        int_in = 1'b1;
        after_edge(2);
        chk("basic_e1_inta0", {31'b0, o_inta[0]}, 32'd1);
        chk("basic_e1_busy0", {31'b0, o_busy[0]}, 32'd0);
        after_edge(1);
        chk("basic_e2_inta0", {31'b0, o_inta[0]}, 32'd0);
        chk("basic_e2_busy0", {31'b0, o_busy[0]}, 32'd1);
        chk("sweep_e2_inta1", {31'b0, o_inta[1]}, 32'd0);
        after_edge(1);
        chk("sweep_e3_inta1", {31'b0, o_inta[1]}, 32'd1);
        after_edge(1);
        chk("basic_e4_inta0", {31'b0, o_inta[0]}, 32'd1);
        after_edge(2);
        chk("basic_e6_inta0", {31'b0, o_inta[0]}, 32'd0);
        chk("sweep_e6_inta1", {31'b0, o_inta[1]}, 32'd0);
        after_edge(1);
        chk("basic_e7_valid0", {31'b0, o_valid[0]}, 32'd0);
        chk("sweep_e7_valid1", {31'b0, o_valid[1]}, 32'd1);
        chk("sweep_e7_vec1", {24'b0, o_vec[1]}, 32'h4B);
        after_edge(1);
        chk("basic_e8_valid0", {31'b0, o_valid[0]}, 32'd1);
        chk("basic_e8_vec0", {24'b0, o_vec[0]}, 32'h4B);
        chk("basic_e8_inta0", {31'b0, o_inta[0]}, 32'd1);

        // Handshake: valid held with int_in still high, then ack
        d_in = 8'h11;
        after_edge(10);
        chk("hold_valid0", {31'b0, o_valid[0]}, 32'd1);
        chk("hold_vec0", {24'b0, o_vec[0]}, 32'h4B);
        vec_ack = 1'b1;
        after_edge(1);
        vec_ack = 1'b0;
        chk("ack_valid0", {31'b0, o_valid[0]}, 32'd0);
        after_edge(1);
        chk("restart_busy0", {31'b0, o_busy[0]}, 32'd1);
        drain();

        // Gating: cpu_ien low blocks the start
        cpu_ien = 1'b0;
        int_in  = 1'b1;
        after_edge(20);
        chk("gate_busy0", {31'b0, o_busy[0]}, 32'd0);
        chk("gate_inta0", {31'b0, o_inta[0]}, 32'd1);
        cpu_ien = 1'b1;
        after_edge(1);
        chk("ungate_busy0", {31'b0, o_busy[0]}, 32'd1);
        chk("ungate_inta0", {31'b0, o_inta[0]}, 32'd0);
        drain();

        // Abort immunity: INT withdrawn before P1 ends, cpu_ien dropped inside P1
        d_in = 8'h0F;
        int_in = 1'b1;
        after_edge(1);
        int_in = 1'b0;
        after_edge(2);
        chk("abort_busy0", {31'b0, o_busy[0]}, 32'd1);
        cpu_ien = 1'b0;
        after_edge(5);
        chk("abort_valid1", {31'b0, o_valid[1]}, 32'd1);
        after_edge(1);
        chk("abort_valid0", {31'b0, o_valid[0]}, 32'd1);
        chk("abort_vec0", {24'b0, o_vec[0]}, 32'h0F);
`ifdef INTA_SPURIOUS_DETECT_EN
        chk("abort_spur0", {31'b0, o_spur[0]}, 32'd1);
        chk("abort_spur1", {31'b0, o_spur[1]}, 32'd1);
`endif
        drain();

        // Reset in the middle of the second pulse
        d_in = 8'h4B;
        int_in = 1'b1;
        after_edge(7);
        chk("pre_rst_inta0", {31'b0, o_inta[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_inta0", {31'b0, o_inta[0]}, 32'd1);
        chk("rst_inta1", {31'b0, o_inta[1]}, 32'd1);
        chk("rst_busy0", {31'b0, o_busy[0]}, 32'd0);
        chk("rst_valid0", {31'b0, o_valid[0]}, 32'd0);
        chk("rst_vec0", {24'b0, o_vec[0]}, 32'h00);
        #2 rst_n = 1'b1;
        after_edge(9);
        chk("post_rst_valid0", {31'b0, o_valid[0]}, 32'd1);
        chk("post_rst_vec0", {24'b0, o_vec[0]}, 32'h4B);
        drain();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #2;
            if ($urandom_range(0, 7) == 0) int_in = ~int_in;
            if ($urandom_range(0, 15) == 0) cpu_ien = ~cpu_ien;
            vec_ack = ($urandom_range(0, 3) == 0);
            d_in = 8'($urandom);
        end
        vec_ack = 1'b0;
        after_edge(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
